// File: rtl/contador_param.sv
// contador_param: parametrised up/down counter with programmable modulus, variable step,
// parallel load, count enable, per-cycle wrap/saturate choice, terminal-count pulse and
// sticky overflow/underflow flags. All outputs are registered.
//
// Parameters:
//   WIDTH    counter width in bits (>= 1)
//   MAX_VAL  terminal value, counting range 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1)
//   STEP_W   width of the step input (<= WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         count enable
//   mode       0 = up, 1 = down
//   load       parallel load strobe (beats counting)
//   load_val   value to load, clamped to MAX_VAL
//   step       increment/decrement amount, legal 0..MAX_VAL
//   sat        0 = wrap modulo MAX_VAL+1, 1 = saturate at 0/MAX_VAL
//   clr_flags  clears sticky ovf/unf (a same-edge set wins)
//   q          count value
//   tc         one-cycle pulse after each overflow/underflow event
//   ovf, unf   sticky overflow / underflow flags
//   at_max     q == MAX_VAL
//   at_zero    q == 0
module contador_param #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter int unsigned STEP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_zero
);

  // One extra bit so q + step and q + MAX_VAL + 1 never overflow the arithmetic.
  localparam logic [WIDTH:0] MaxExt = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] ModExt = MaxExt + 1'b1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max_q, at_max_d;
  logic             at_zero_q, at_zero_d;

  logic [WIDTH:0] q_ext, step_ext, load_ext, sum_ext, wrap_up, wrap_dn;
  logic           ovf_evt, unf_evt;

  always_comb begin
    q_ext    = {1'b0, q_q};
    step_ext = (WIDTH + 1)'(step);
    load_ext = {1'b0, load_val};
    sum_ext  = q_ext + step_ext;
    wrap_up  = sum_ext - ModExt;
    wrap_dn  = q_ext + ModExt - step_ext;
    ovf_evt  = (sum_ext > MaxExt);
    unf_evt  = (step_ext > q_ext);
  end

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (load) begin
      q_d = (load_ext > MaxExt) ? MaxExt[WIDTH-1:0] : load_val;
    end else if (en && (step != '0)) begin
      if (!mode) begin
        if (ovf_evt) begin
          // Pushing into a saturated MAX_VAL still counts as an event.
          q_d   = sat ? MaxExt[WIDTH-1:0] : wrap_up[WIDTH-1:0];
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = sum_ext[WIDTH-1:0];
        end
      end else begin
        if (unf_evt) begin
          q_d   = sat ? '0 : wrap_dn[WIDTH-1:0];
          tc_d  = 1'b1;
          unf_d = 1'b1;
        end else begin
          q_d = q_q - step_ext[WIDTH-1:0];
        end
      end
    end
    at_max_d  = ({1'b0, q_d} == MaxExt);
    at_zero_d = (q_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      at_max_q  <= 1'b0;
      at_zero_q <= 1'b1;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      at_max_q  <= at_max_d;
      at_zero_q <= at_zero_d;
    end
  end

  assign q       = q_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign at_max  = at_max_q;
  assign at_zero = at_zero_q;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: one instance with MAX_VAL=9 and one with default
// parameters, both fed the same inputs and checked every cycle against an arithmetic model.
module tb_contador_param;

  logic       clk = 1'b0;
  logic       reset, en, mode, load, sat, clr_flags;
  logic [7:0] load_val;
  logic [3:0] step;

  logic [7:0] q_a, q_b;
  logic       tc_a, ovf_a, unf_a, at_max_a, at_zero_a;
  logic       tc_b, ovf_b, unf_b, at_max_b, at_zero_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 = MAX_VAL 9, index 1 = MAX_VAL 255.
  int mq[2], mtc[2], movf[2], munf[2];
  int mmax[2] = '{9, 255};

  always #5 clk = ~clk;

  contador_param #(.WIDTH(8), .MAX_VAL(9), .STEP_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .step(step), .sat(sat), .clr_flags(clr_flags), .q(q_a), .tc(tc_a), .ovf(ovf_a),
    .unf(unf_a), .at_max(at_max_a), .at_zero(at_zero_a)
  );

  contador_param u_dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .step(step), .sat(sat), .clr_flags(clr_flags), .q(q_b), .tc(tc_b), .ovf(ovf_b),
    .unf(unf_b), .at_max(at_max_b), .at_zero(at_zero_b)
  );

  // Steps above the smaller instance's MAX_VAL are illegal.
  always @(posedge clk) begin
    if (!reset) assert (step <= 4'd9) else $error("illegal step %0d", step);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int m, t;
    for (int k = 0; k < 2; k++) begin
      m = mmax[k] + 1;
      if (reset) begin
        mq[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
      end else begin
        mtc[k] = 0;
        if (clr_flags) begin
          movf[k] = 0; munf[k] = 0;
        end
        if (load) begin
          mq[k] = (int'(load_val) > mmax[k]) ? mmax[k] : int'(load_val);
        end else if (en && step != 0) begin
          t = mode ? mq[k] - int'(step) : mq[k] + int'(step);
          if (t < 0 || t > mmax[k]) begin
            mtc[k] = 1;
            if (mode) munf[k] = 1;
            else      movf[k] = 1;
            if (sat) mq[k] = mode ? 0 : mmax[k];
            else     mq[k] = ((t % m) + m) % m;
          end else begin
            mq[k] = t;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_q", 32'(q_a), mq[0]);
    check("a_tc", 32'(tc_a), mtc[0]);
    check("a_ovf", 32'(ovf_a), movf[0]);
    check("a_unf", 32'(unf_a), munf[0]);
    check("a_at_max", 32'(at_max_a), 32'(mq[0] == mmax[0]));
    check("a_at_zero", 32'(at_zero_a), 32'(mq[0] == 0));
    check("b_q", 32'(q_b), mq[1]);
    check("b_tc", 32'(tc_b), mtc[1]);
    check("b_ovf", 32'(ovf_b), movf[1]);
    check("b_unf", 32'(unf_b), munf[1]);
    check("b_at_max", 32'(at_max_b), 32'(mq[1] == mmax[1]));
    check("b_at_zero", 32'(at_zero_b), 32'(mq[1] == 0));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sat = 1'b0; clr_flags = 1'b0;
    load_val = 8'd0; step = 4'd1;
    @(negedge clk);
    tick();
    check("rst_q", 32'(q_a), 0);
    check("rst_at_zero", 32'(at_zero_a), 1);

    // Wrap up
    reset = 1'b0; en = 1'b1; mode = 1'b0; step = 4'd1; sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("wrapup_q", 32'(q_a), (i + 1) % 10);
      check("wrapup_tc", 32'(tc_a), 32'(i == 9));
      check("wrapup_ovf", 32'(ovf_a), 32'(i >= 9));
      check("wrapup_unf", 32'(unf_a), 0);
    end

    // Wrap down
    load = 1'b1; load_val = 8'd2; tick();
    load = 1'b0; mode = 1'b1; step = 4'd3; tick();
    check("wrapdn_q", 32'(q_a), 9);
    check("wrapdn_tc", 32'(tc_a), 1);
    check("wrapdn_unf", 32'(unf_a), 1);
    tick();
    check("wrapdn_q2", 32'(q_a), 6);
    check("wrapdn_tc2", 32'(tc_a), 0);

    // Saturation up
    load = 1'b1; load_val = 8'd7; tick();
    load = 1'b0; mode = 1'b0; step = 4'd4; sat = 1'b1;
    tick();
    check("satup_q1", 32'(q_a), 9);
    check("satup_tc1", 32'(tc_a), 1);
    tick();
    check("satup_q2", 32'(q_a), 9);
    check("satup_tc2", 32'(tc_a), 1);

    // Saturation down
    mode = 1'b1; step = 4'd5;
    tick();
    check("satdn_q1", 32'(q_a), 4);
    check("satdn_tc1", 32'(tc_a), 0);
    tick();
    check("satdn_q2", 32'(q_a), 0);
    check("satdn_tc2", 32'(tc_a), 1);
    check("satdn_unf", 32'(unf_a), 1);

    // Priority and clamping
    sat = 1'b0; mode = 1'b0; step = 4'd3;
    load = 1'b1; load_val = 8'd5; tick();
    check("load_q", 32'(q_a), 5);
    check("load_tc", 32'(tc_a), 0);
    load_val = 8'd200; tick();
    check("clamp_q", 32'(q_a), 9);
    check("clamp_at_max", 32'(at_max_a), 1);
    check("noclamp_b_q", 32'(q_b), 200);
    reset = 1'b1; tick();
    check("rstload_q", 32'(q_a), 0);
    check("rstload_at_zero", 32'(at_zero_a), 1);
    reset = 1'b0; load_val = 8'd5; tick();
    load = 1'b0; en = 1'b0; tick();
    check("hold_en_q", 32'(q_a), 5);
    check("hold_en_tc", 32'(tc_a), 0);
    en = 1'b1; step = 4'd0; tick();
    check("hold_step_q", 32'(q_a), 5);
    check("hold_step_tc", 32'(tc_a), 0);

    // Flags
    load = 1'b1; load_val = 8'd8; tick();
    load = 1'b0; step = 4'd3; clr_flags = 1'b1; tick();
    check("setclr_q", 32'(q_a), 1);
    check("setclr_ovf", 32'(ovf_a), 1);
    en = 1'b0; tick();
    check("clr_ovf", 32'(ovf_a), 0);
    check("clr_unf", 32'(unf_a), 0);
    clr_flags = 1'b0;

    // Default parameters: 255 + 1 wraps to 0
    load = 1'b1; load_val = 8'd255; tick();
    check("def_load_q", 32'(q_b), 255);
    load = 1'b0; en = 1'b1; step = 4'd1; sat = 1'b0; mode = 1'b0; tick();
    check("def_wrap_q", 32'(q_b), 0);
    check("def_wrap_tc", 32'(tc_b), 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      load      = ($urandom_range(0, 7) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      sat       = 1'($urandom);
      clr_flags = ($urandom_range(0, 15) == 0);
      load_val  = 8'($urandom);
      step      = 4'($urandom_range(0, 9));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised up/down counter that generalises the team's 8-bit counter. It adds a programmable modulus, a variable step, parallel load, count enable, a per-cycle choice of wrap or saturate, and terminal-count and sticky overflow/underflow status. It is a drop-in building block for timers, dividers and BCD/modulo sequencers in the verification projects. All outputs are registered.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; must be at least 1.
- MAX_VAL, 2**WIDTH-1, terminal value; the counting range is 0..MAX_VAL; requires 1 <= MAX_VAL <= 2**WIDTH-1.
- STEP_W, 4, width of the step input; requires STEP_W <= WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- step  in  STEP_W  increment/decrement amount; legal range 0..MAX_VAL.
- sat  in  1  0 = wrap modulo MAX_VAL+1, 1 = saturate at 0/MAX_VAL.
- clr_flags  in  1  clears the sticky ovf/unf flags.
- q  out  WIDTH  count value.
- tc  out  1  one-cycle pulse for each boundary event.
- ovf  out  1  sticky flag: an up-count crossed MAX_VAL.
- unf  out  1  sticky flag: a down-count went below 0.
- at_max  out  1  high when q == MAX_VAL.
- at_zero  out  1  high when q == 0.

## Operation
- Per-edge priority: reset > load > (en && step != 0) > hold.
- Reset: q=0, tc=0, ovf=0, unf=0, at_zero=1, at_max=0.
- Load:
  - q = min(load_val, MAX_VAL).
  - tc=0; ovf and unf are not set by a load.
  - clr_flags is still honoured in the same cycle.
- Up count (mode=0): compute s = q + step with at least WIDTH+1 bits.
  - If s <= MAX_VAL: q = s, no event.
  - If s > MAX_VAL: this is an overflow event.
  - On overflow with sat=0: q = s - (MAX_VAL+1).
  - On overflow with sat=1: q = MAX_VAL.
- Down count (mode=1):
  - If step <= q: q = q - step, no event.
  - If step > q: this is an underflow event.
  - On underflow with sat=0: q = q + (MAX_VAL+1) - step.
  - On underflow with sat=1: q = 0.
- Events in saturation: counting further into a saturated boundary is still an event. For example, q=MAX_VAL with up, sat=1, step>0 gives q=MAX_VAL and tc=1 every cycle.
- tc: registered; equals 1 exactly in the cycle after an edge on which an overflow or underflow event occurred, otherwise 0.
- Sticky flags:
  - ovf is set by an overflow event and unf by an underflow event.
  - Both are cleared by clr_flags or reset.
  - Setting beats clearing on the same edge.
- at_max and at_zero are registered from the next value of q, so they are always coherent with q.
- en=0, or en=1 with step=0: q holds, tc=0, flags unchanged apart from clr_flags.
- mode and sat are sampled every edge; changing them mid-count takes effect on that edge.
- step > MAX_VAL is illegal. The bench asserts it never occurs; RTL behaviour for it is undefined.

## Timing
- Single clock domain, no combinational input-to-output paths.
- Latency is one cycle: inputs sampled at edge N are visible on q and all flags after edge N.
- Reset asserted in the middle of counting or loading forces the reset values on that same edge, whatever the other inputs are.
- A count can be sustained on every cycle; there are no bubbles and no handshake.

## Test plan
(MAX_VAL=9, STEP_W=4, WIDTH=8 unless stated.)
- Wrap up: reset; en=1, mode=0, step=1, sat=0 for 12 edges.
  - q = 1..9, 0, 1, 2.
  - tc=1 only in the cycle q=0 appears.
  - ovf=1 from then on; unf=0.
- Wrap down: load 2; then en=1, mode=1, step=3, sat=0 for one edge.
  - q=9, tc=1, unf=1.
  - One more edge gives q=6 and tc=0.
- Saturation up: load 7; then mode=0, step=4, sat=1 for two edges.
  - q=9, then q=9.
  - tc=1 on both cycles.
- Saturation down: from q=9, set mode=1, step=5 for two edges.
  - q=4 with tc=0, then q=0 with tc=1.
  - unf=1.
- Priority and clamping:
  - load=1 with en=1 and load_val=5: q=5, tc=0.
  - load_val=200: q=9, at_max=1.
  - reset=1 with load=1: q=0, at_zero=1.
  - en=0, or step=0: q holds and tc=0.
- Flags and defaults:
  - clr_flags on the same edge as an overflow event: ovf stays 1.
  - clr_flags alone: ovf=0 and unf=0.
  - With default parameters (MAX_VAL=255), up-counting with step=1 from 255 gives q=0 and tc=1.
